pe_weight_streamer: RTL
=======================

Name: pe_weight_streamer

Overview:
- Column-head weight transmitter for the systolic array.
- Accepts one tile of NUM_ROWS*WEIGHT_DEPTH weights from the DMA/memory side as an AXI-Stream in row-major order (row 0 first) and buffers the whole tile.
- Re-emits the tile on an AXI-Stream master into the top PE's vertical weight input, in reverse-row order, so that daisy-chained propagation leaves each PE holding its own weights.
- Drives the PE column's weight_load_enable while draining.

Parameters:
- WEIGHT_WIDTH, 16: weight word width (fp16).
- WEIGHT_DEPTH, 4: weight slots per PE.
- NUM_ROWS, 4: PEs in the column.
- Derived, not overridable: TILE_WORDS = NUM_ROWS*WEIGHT_DEPTH; AW = $clog2(TILE_WORDS).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse that begins a tile load; honoured only in IDLE
- busy  out  1  high in FILL and DRAIN
- done  out  1  one-cycle pulse after the final output beat
- err_len  out  1  sticky tlast/length error; cleared by rst or an accepted start
- s_axis_tvalid  in  1  input weight beat valid
- s_axis_tready  out  1  input ready
- s_axis_tdata  in  WEIGHT_WIDTH  input weight
- s_axis_tlast  in  1  marks the last word of the tile
- m_axis_tvalid  out  1  output weight valid (to PE v_weight_in_tvalid)
- m_axis_tready  in  1  from PE v_weight_in_tready
- m_axis_tdata  out  WEIGHT_WIDTH  output weight
- m_axis_tlast  out  1  high on the final output word
- weight_load_enable  out  1  to the PE column; high throughout DRAIN

Behaviour:
- Reset: state=IDLE, counters=0; all outputs are 0, including s_axis_tready, m_axis_tvalid, m_axis_tlast, busy, done, err_len and weight_load_enable. Buffer contents are don't-care.
- Reset mid-FILL or mid-DRAIN: abandons the tile next edge; no done pulse.
- IDLE:
  - s_axis_tready=0.
  - start -> FILL; err_len cleared; wr_cnt=0.
- FILL:
  - s_axis_tready=1 (registered; first ready is the cycle after start).
  - Each handshake writes buf[wr_cnt] and increments wr_cnt.
  - wr_cnt==TILE_WORDS-1 with handshake -> DRAIN. If tlast=0 on that beat, set err_len and still proceed.
  - tlast=1 with wr_cnt<TILE_WORDS-1 -> set err_len, return to IDLE, no drain, no done.
- DRAIN:
  - Output beat k (k=0..TILE_WORDS-1) carries buf[(NUM_ROWS-1-r)*WEIGHT_DEPTH + s], with r=k/WEIGHT_DEPTH and s=k%WEIGHT_DEPTH. Row counter and slot counter are separate; no divider.
  - First m_axis_tvalid is exactly one cycle after entering DRAIN, from a registered buffer read.
  - Each subsequent beat may be presented in the cycle after the previous handshake. Full throughput is one word per cycle when tready stays high.
  - AXI rule: once m_axis_tvalid=1, tvalid/tdata/tlast hold stable until the handshake.
  - m_axis_tlast=1 only on k=TILE_WORDS-1.
  - Handshake on the last beat -> DONE.
  - s_axis_tready=0 throughout DRAIN; no double-buffering.
- DONE: done=1 for one cycle, then IDLE. busy=0 in DONE.
- start outside IDLE is ignored: no effect on state or err_len.
- Counter wrap: wr_cnt and the row/slot counters never exceed TILE_WORDS-1 and reset at state entry. A non-power-of-2 TILE_WORDS is legal.

Decomposition:
- Shared package pe_array_pkg holds:
  - default WEIGHT_WIDTH, WEIGHT_DEPTH, NUM_ROWS, shared with the PE and array top;
  - the streamer state encoding (IDLE, FILL, DRAIN, DONE).
- One sub-module: weight_tile_ram, a simple dual-port RAM with TILE_WORDS x WEIGHT_WIDTH, synchronous write and 1-cycle registered read. It maps to LUTRAM/BRAM.
- FSM and address generation stay in pe_weight_streamer.

Test Plan (NUM_ROWS=4, WEIGHT_DEPTH=4):
1. Basic reorder:
   - Stimulus: start; feed 16 words 0x3C00+i (i=0..15) with tlast on i=15; m_axis_tready=1.
   - Response: out order 0x3C0C,0D,0E,0F,0x3C08..0B,0x3C04..07,0x3C00..03; tlast only on 0x3C03; done one cycle later; err_len=0.
2. Backpressure:
   - Stimulus: same tile; m_axis_tready toggles 1,0,0,1 repeatedly.
   - Response: every word appears once, in the same order as test 1; tdata/tlast stable while stalled; weight_load_enable high for the whole drain.
3. Early tlast:
   - Stimulus: tlast on beat 9.
   - Response: err_len=1; return to IDLE; m_axis_tvalid never asserts; no done. A following start clears err_len, and a correct tile then drains normally.
4. Missing tlast:
   - Stimulus: 16 beats, tlast=0 throughout.
   - Response: err_len=1; drain still emits all 16 words in the correct order; done pulses.
5. Start while busy:
   - Stimulus: pulse start during FILL beat 5 and again during DRAIN.
   - Response: no restart; counts and order unchanged.
6. Reset mid-drain:
   - Stimulus: assert rst after 6 output beats.
   - Response: next cycle all outputs are 0 and state is IDLE. A new start with a fresh tile yields the correct full sequence.

Source files
------------

// File: rtl/pe_array_pkg.sv
// Shared defaults for the PE array and the column-head weight streamer state encoding.
package pe_array_pkg;

    localparam int unsigned DefWeightWidth = 16;
    localparam int unsigned DefWeightDepth = 4;
    localparam int unsigned DefNumRows     = 4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFill  = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } streamer_state_e;

    // Counter width that stays at least one bit for degenerate sizes.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/weight_tile_ram.sv
// Simple dual-port tile buffer: synchronous write, one-cycle registered read.
module weight_tile_ram #(
    parameter int unsigned Width = 16,
    parameter int unsigned Depth = 16,
    parameter int unsigned Aw    = 4
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [Aw-1:0]    waddr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             re_i,
    input  logic [Aw-1:0]    raddr_i,
    output logic [Width-1:0] rdata_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/pe_weight_streamer.sv
// Buffers one weight tile in row-major order and re-emits it rows-reversed into the PE column.
module pe_weight_streamer
    import pe_array_pkg::*;
#(
    parameter int unsigned WEIGHT_WIDTH = DefWeightWidth,
    parameter int unsigned WEIGHT_DEPTH = DefWeightDepth,
    parameter int unsigned NUM_ROWS     = DefNumRows
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    err_len,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic [WEIGHT_WIDTH-1:0] s_axis_tdata,
    input  logic                    s_axis_tlast,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [WEIGHT_WIDTH-1:0] m_axis_tdata,
    output logic                    m_axis_tlast,
    output logic                    weight_load_enable
);

    localparam int unsigned TILE_WORDS = NUM_ROWS * WEIGHT_DEPTH;
    localparam int unsigned AW         = cnt_width(TILE_WORDS);
    localparam int unsigned RW         = cnt_width(NUM_ROWS);
    localparam int unsigned SW         = cnt_width(WEIGHT_DEPTH);
    localparam logic [AW-1:0] LastBase = AW'((NUM_ROWS - 1) * WEIGHT_DEPTH);

    streamer_state_e state_q, state_d;

    logic [AW-1:0] wr_cnt_q, wr_cnt_d;
    logic [RW-1:0] row_q, row_d;
    logic [SW-1:0] slot_q, slot_d;
    logic [AW-1:0] base_q, base_d;
    logic          issued_all_q, issued_all_d;
    logic          m_valid_q, m_valid_d;
    logic          m_last_q, m_last_d;
    logic          err_len_q, err_len_d;

    logic                    start_acc, s_hs, m_hs, fill_last, fill_to_drain;
    logic                    rd_issue, slot_last, row_last;
    logic [AW-1:0]           raddr;
    logic [WEIGHT_WIDTH-1:0] rdata;

    assign start_acc     = (state_q == StIdle) && start;
    assign s_hs          = (state_q == StFill) && s_axis_tvalid;
    assign fill_last     = (wr_cnt_q == AW'(TILE_WORDS - 1));
    assign fill_to_drain = s_hs && fill_last;
    assign m_hs          = m_valid_q && m_axis_tready;
    assign slot_last     = (slot_q == SW'(WEIGHT_DEPTH - 1));
    assign row_last      = (row_q == RW'(NUM_ROWS - 1));
    // Refill the output stage whenever it is empty or being drained this cycle.
    assign rd_issue      = (state_q == StDrain) && !issued_all_q && (!m_valid_q || m_axis_tready);
    assign raddr         = base_q + AW'(slot_q);

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StFill;
            StFill: begin
                if (s_hs && fill_last)         state_d = StDrain;
                else if (s_hs && s_axis_tlast) state_d = StIdle;
            end
            StDrain: if (m_hs && m_last_q) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        s_axis_tready      = (state_q == StFill);
        busy               = (state_q == StFill) || (state_q == StDrain);
        done               = (state_q == StDone);
        weight_load_enable = (state_q == StDrain);
    end

    // Write counter, reversed-row read address generation and output stage.
    always_comb begin
        wr_cnt_d     = wr_cnt_q;
        err_len_d    = err_len_q;
        row_d        = row_q;
        slot_d       = slot_q;
        base_d       = base_q;
        issued_all_d = issued_all_q;
        m_last_d     = m_last_q;

        if (start_acc) begin
            wr_cnt_d  = '0;
            err_len_d = 1'b0;
        end
        if (s_hs) begin
            wr_cnt_d = fill_last ? '0 : wr_cnt_q + 1'b1;
            // Covers both a missing tlast on the final word and an early tlast.
            if (fill_last != s_axis_tlast) err_len_d = 1'b1;
        end
        if (fill_to_drain) begin
            row_d        = '0;
            slot_d       = '0;
            base_d       = LastBase;
            issued_all_d = 1'b0;
        end
        if (rd_issue) begin
            m_last_d = slot_last && row_last;
            if (!slot_last) begin
                slot_d = slot_q + 1'b1;
            end else begin
                slot_d = '0;
                if (row_last) begin
                    row_d        = '0;
                    issued_all_d = 1'b1;
                end else begin
                    row_d  = row_q + 1'b1;
                    base_d = base_q - AW'(WEIGHT_DEPTH);
                end
            end
        end else if (m_hs) begin
            m_last_d = 1'b0;
        end
        m_valid_d = rd_issue || (m_valid_q && !m_axis_tready);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt_q     <= '0;
            err_len_q    <= 1'b0;
            row_q        <= '0;
            slot_q       <= '0;
            base_q       <= LastBase;
            issued_all_q <= 1'b0;
            m_valid_q    <= 1'b0;
            m_last_q     <= 1'b0;
        end else begin
            wr_cnt_q     <= wr_cnt_d;
            err_len_q    <= err_len_d;
            row_q        <= row_d;
            slot_q       <= slot_d;
            base_q       <= base_d;
            issued_all_q <= issued_all_d;
            m_valid_q    <= m_valid_d;
            m_last_q     <= m_last_d;
        end
    end

    weight_tile_ram #(
        .Width (WEIGHT_WIDTH),
        .Depth (TILE_WORDS),
        .Aw    (AW)
    ) u_tile_ram (
        .clk_i   (clk),
        .we_i    (s_hs),
        .waddr_i (wr_cnt_q),
        .wdata_i (s_axis_tdata),
        .re_i    (rd_issue),
        .raddr_i (raddr),
        .rdata_o (rdata)
    );

    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tlast  = m_last_q;
    assign m_axis_tdata  = m_valid_q ? rdata : '0;
    assign err_len       = err_len_q;

endmodule
